// File: rtl/float64_mul_arbiter.sv
// Round-robin arbiter sharing one ap_ctrl float64 multiplier among
// NUM_REQ requesters, with a watchdog that turns a stuck multiply into an error.
module float64_mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 1024
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        resp_valid,
    input  logic [NUM_REQ-1:0]        resp_ready,
    output logic [DATA_W-1:0]         resp_data,
    output logic                      resp_err,
    output logic                      mul_ap_start,
    input  logic                      mul_ap_ready,
    input  logic                      mul_ap_done,
    output logic [DATA_W-1:0]         mul_a,
    output logic [DATA_W-1:0]         mul_b,
    input  logic [DATA_W-1:0]         mul_ap_return,
    output logic                      busy,
    output logic [2:0]                grant_id
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_ISSUE = 4'b0010,
        S_WAIT  = 4'b0100,
        S_RESP  = 4'b1000
    } state_t;

    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    state_t              state;
    logic [2:0]          last_grant;
    logic [15:0]         wd;
    logic [DATA_W-1:0]   result;
    logic [2:0]          winner;
    logic                any_req;
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]  rot;
    logic [DATA_W-1:0]   sel_a;
    logic [DATA_W-1:0]   sel_b;
    logic                wd_expired;
    int                  sh;
    int                  k;

    // Rotate requests so the slot after last_grant is bit 0, then pick lowest set bit
    always_comb begin
        any_req = |req_valid;
        sh      = (int'(last_grant) + 1) % NUM_REQ;
        dbl     = {req_valid, req_valid} >> sh;
        rot     = dbl[NUM_REQ-1:0];
        k       = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) k = i;
        end
        winner = 3'((sh + k) % NUM_REQ);
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == 3'(i)) begin
                sel_a = req_a[i*DATA_W +: DATA_W];
                sel_b = req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    // Handshake strobes and status decoded from the registered state
    always_comb begin
        req_ready    = (state == S_IDLE && any_req) ? (ONE << winner) : '0;
        resp_valid   = (state == S_RESP) ? (ONE << grant_id) : '0;
        mul_ap_start = (state == S_ISSUE);
        busy         = (state != S_IDLE);
        resp_data    = result;
        wd_expired   = (wd == 16'(TIMEOUT - 1));
    end

    // Control FSM: accept, issue, wait for done or watchdog, respond
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state      <= S_IDLE;
            last_grant <= 3'(NUM_REQ - 1);
            grant_id   <= '0;
            wd         <= '0;
            result     <= '0;
            resp_err   <= 1'b0;
            mul_a      <= '0;
            mul_b      <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (any_req) begin
                        mul_a    <= sel_a;
                        mul_b    <= sel_b;
                        grant_id <= winner;
                        wd       <= '0;
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wd <= wd + 16'd1;
                    if (mul_ap_ready && mul_ap_done) begin
                        result   <= mul_ap_return;
                        resp_err <= 1'b0;
                        state    <= S_RESP;
                    end else if (wd_expired) begin
                        result   <= '0;
                        resp_err <= 1'b1;
                        state    <= S_RESP;
                    end else if (mul_ap_ready) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    wd <= wd + 16'd1;
                    if (mul_ap_done) begin
                        result   <= mul_ap_return;
                        resp_err <= 1'b0;
                        state    <= S_RESP;
                    end else if (wd_expired) begin
                        result   <= '0;
                        resp_err <= 1'b1;
                        state    <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (|(resp_ready & resp_valid)) begin
                        last_grant <= grant_id;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
